wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback end of the wb_sel path: takes a retiring instruction with its decoded wb_sel,
//  selects load data / ALU result / PC+4, formats sub-word loads and drives the register-file
//  write port. Stalls upstream while a load response is outstanding; also drives forwarding outputs.
// PARAMETERS
//  XLEN          32   datapath width; only 32 is supported
//  LOAD_TIMEOUT  16   max cycles in WAIT_LOAD before abort; must be >= 2
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  rst          in   1     synchronous active-high reset
//  in_valid     in   1     instruction/operands valid this cycle
//  in_ready     out  1     block can accept; in_ready = (state == IDLE)
//  instruction  in   32    retiring instruction: opcode [6:0], rd [11:7], funct3 [14:12]
//  wb_sel       in   2     00 = mem data, 01 = ALU, 10 = PC+4, 11 = reserved
//  alu_result   in   32    ALU result; for loads, the address ([1:0] = byte offset)
//  pc_plus4     in   32    link value
//  mem_rvalid   in   1     load data valid; sampled only in WAIT_LOAD
//  mem_rdata    in   32    aligned 32-bit load word
//  rf_we        out  1     register-file write enable, one-cycle pulse per write
//  rf_waddr     out  5     destination register
//  rf_wdata     out  32    write data
//  fwd_valid    out  1     equals rf_we
//  fwd_rd       out  5     equals rf_waddr
//  fwd_data     out  32    equals rf_wdata
//  busy         out  1     state == WAIT_LOAD
//  err          out  1     one-cycle pulse: misaligned or illegal load, or load timeout
// BEHAVIOUR
//  Reset
//   - State := IDLE. rf_we, err, fwd_valid := 0. rf_waddr, fwd_rd := 0. rf_wdata, fwd_data := 0.
//   - Timeout counter := 0. Any captured load context is discarded.
//  Write-rd opcodes
//   - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011.
//   - All other opcodes are accepted and produce no write.
//   - rd == 0 never writes: rf_we stays 0.
//  Acceptance: in_valid & in_ready.
//  IDLE, non-load accepted
//   - Next cycle: rf_we = 1 if the opcode is a write-rd opcode and rd != 0 and wb_sel != 11.
//   - rf_wdata = alu_result for wb_sel 01, pc_plus4 for wb_sel 10.
//   - wb_sel 00 on a non-load writes alu_result.
//   - wb_sel 11 suppresses the write and pulses err.
//   - Stays in IDLE; back-to-back accepts give one write per cycle.
//  IDLE, load accepted
//   - Capture rd, funct3 and alu_result[1:0]; clear the counter; go to WAIT_LOAD.
//   - Illegal funct3 (not 000/001/010/100/101): err pulses next cycle, no write, stay IDLE.
//   - Misaligned LH/LHU (off[0] = 1) or LW (off != 0): err pulses next cycle, no write, stay IDLE.
//  WAIT_LOAD (in_ready = 0)
//   - mem_rvalid = 1: next cycle rf_we = (rd != 0) with formatted data; return to IDLE.
//   - Otherwise the counter increments.
//   - Counter == LOAD_TIMEOUT-1 with no rvalid: err pulses next cycle, no write, go to IDLE.
//   - rvalid in the same cycle as the timeout: the data is written and err stays 0.
//  Load format (byte b = mem_rdata[8*off +: 8], half h = mem_rdata[16*off[1] +: 16])
//   - LB: sign-extend b. LBU: zero-extend b.
//   - LH: sign-extend h. LHU: zero-extend h.
//   - LW: mem_rdata.
//  mem_rvalid in IDLE is ignored.
//  rst while in WAIT_LOAD
//   - Return to IDLE with no write.
//   - A later rvalid is ignored.
//  Latency: non-load 1 cycle from accept; load 1 cycle from mem_rvalid.
// TESTING
//  1 OP x5, wb_sel = 01, alu_result = 0x0000_1234 -> next cycle rf_we = 1, waddr = 5,
//    wdata = 0x0000_1234; fwd_* match.
//  2 LB x7, off = 2; rvalid 3 cycles later with rdata = 0x0080_0000 -> one cycle later
//    wdata = 0xFFFF_FF80; in_ready low while waiting.
//  3 JAL x0, wb_sel = 10 -> rf_we stays 0, err = 0; then LBU x1, off = 3,
//    rdata = 0xAB00_0000 -> wdata = 0x0000_00AB.
//  4 LW x3 with no rvalid, LOAD_TIMEOUT = 16 -> err pulses once, no write, in_ready returns.
//  5 LH x4 at off = 1 -> err next cycle, busy never set. rst during WAIT_LOAD, then rvalid
//    -> no write.
//  6 Four back-to-back OP-IMM accepts -> four consecutive rf_we pulses in order,
//    in_ready held high.

Source files
------------

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
//   Writeback end of the wb_sel path. A retiring instruction is accepted in
//   IDLE. Non-loads write the ALU result or PC+4 one cycle later. Legal loads
//   park in WAIT_LOAD until mem_rvalid, then write the formatted sub-word data.
//   Loads that are illegal, misaligned or time out raise a one-cycle err pulse.
//   The forwarding outputs are copies of the register-file write port.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   in_valid         instruction/operands valid this cycle
//   in_ready         high only in IDLE
//   instruction      opcode [6:0], rd [11:7], funct3 [14:12]
//   wb_sel           00 mem, 01 ALU, 10 PC+4, 11 reserved
//   alu_result       ALU result, or the load address for loads
//   pc_plus4         link value
//   mem_rvalid       load data valid (sampled only in WAIT_LOAD)
//   mem_rdata        aligned 32-bit load word
//   rf_we/waddr/wdata register-file write port (we is a one-cycle pulse)
//   fwd_valid/rd/data copies of the write port for forwarding
//   busy             high while in WAIT_LOAD
//   err              one-cycle error pulse
//
// Handshake: an instruction is taken on a rising edge where in_valid and
// in_ready are both high; in_valid may be held without being taken, and the
// inputs only need to be stable on the accepting edge.
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [1:0]      wb_sel,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            busy,
  output logic            err
);

  localparam logic [0:0] S_IDLE      = 1'b0;
  localparam logic [0:0] S_WAIT_LOAD = 1'b1;

  localparam int              CW     = $clog2(LOAD_TIMEOUT) + 1;
  localparam logic [CW-1:0]   C_LAST = CW'(LOAD_TIMEOUT - 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // State and captured load context
  logic [0:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_rd;
  logic [2:0]      r_f3;
  logic [1:0]      r_off;
  logic            r_rf_we;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_err;

  // Decode of the incoming instruction
  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_f3;
  logic [1:0]      w_off;
  logic            w_accept;
  logic            w_is_load;
  logic            w_writes_rd;
  logic            w_f3_legal;
  logic            w_misaligned;
  logic            w_unused_bits;

  // Load formatting
  logic [XLEN-1:0] w_shifted;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_data;

  assign w_opcode      = instruction[6:0];
  assign w_rd          = instruction[11:7];
  assign w_f3          = instruction[14:12];
  assign w_off         = alu_result[1:0];
  assign w_unused_bits = ^instruction[31:15];

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_WAIT_LOAD);
  assign w_accept  = in_valid & in_ready;
  assign w_is_load = (w_opcode == OPC_LOAD);

  assign w_writes_rd = (w_opcode == OPC_LUI)    || (w_opcode == OPC_AUIPC) ||
                       (w_opcode == OPC_JAL)    || (w_opcode == OPC_JALR)  ||
                       (w_opcode == OPC_OP_IMM) || (w_opcode == OPC_OP);

  assign w_f3_legal = (w_f3 == F3_LB)  || (w_f3 == F3_LH) || (w_f3 == F3_LW) ||
                      (w_f3 == F3_LBU) || (w_f3 == F3_LHU);

  // Halfwords need an even offset, words need offset 0; bytes are always fine.
  assign w_misaligned = (((w_f3 == F3_LH) || (w_f3 == F3_LHU)) && w_off[0]) ||
                        ((w_f3 == F3_LW) && (w_off != 2'b00));

  assign w_shifted = mem_rdata >> {r_off, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load_data = mem_rdata;
    case (r_f3)
      F3_LB:   w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_f3       <= '0;
      r_off      <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rf_we <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_load) begin
              if (!w_f3_legal || w_misaligned) begin
                r_err <= 1'b1;
              end else begin
                r_rd    <= w_rd;
                r_f3    <= w_f3;
                r_off   <= w_off;
                r_cnt   <= '0;
                r_state <= S_WAIT_LOAD;
              end
            end else if (wb_sel == 2'b11) begin
              r_err <= 1'b1;
            end else if (w_writes_rd && (w_rd != 5'd0)) begin
              // wb_sel 00 on a non-load has no memory data, so it takes the ALU result.
              r_rf_we    <= 1'b1;
              r_rf_waddr <= w_rd;
              r_rf_wdata <= (wb_sel == 2'b10) ? pc_plus4 : alu_result;
            end
          end
        end
        S_WAIT_LOAD: begin
          // rvalid wins over a timeout landing on the same edge.
          if (mem_rvalid) begin
            if (r_rd != 5'd0) begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= r_rd;
              r_rf_wdata <= w_load_data;
            end
            r_state <= S_IDLE;
          end else if (r_cnt == C_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign fwd_valid = r_rf_we;
  assign fwd_rd    = r_rf_waddr;
  assign fwd_data  = r_rf_wdata;
  assign err       = r_err;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [1:0]  wb_sel;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected event: {is_err, waddr, wdata}
  logic [37:0] exp_q[$];

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  wb_stage #(.XLEN(32), .LOAD_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .wb_sel      (wb_sel),
    .alu_result  (alu_result),
    .pc_plus4    (pc_plus4),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .busy        (busy),
    .err         (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                     input logic [2:0] f3);
    mk = {17'd0, f3, rd, opc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({1'b0, rd, data});
  endtask

  task automatic push_err();
    exp_q.push_back({1'b1, 5'd0, 32'd0});
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic issue(input logic [31:0] instr, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc);
    int waited = 0;
    instruction = instr;
    wb_sel      = sel;
    alu_result  = alu;
    pc_plus4    = pc;
    in_valid    = 1'b1;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_wait: in_ready stayed 0 for %0d cycles, expected 1", waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic rvalid_pulse(input logic [31:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst && (rf_we || err)) begin
      n_checks++;
      if (fwd_valid !== rf_we || fwd_rd !== rf_waddr || fwd_data !== rf_wdata) begin
        n_fail++;
        $display("FAIL fwd_copy: got %0b/%0d/0x%08h, expected %0b/%0d/0x%08h",
                 fwd_valid, fwd_rd, fwd_data, rf_we, rf_waddr, rf_wdata);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got we=%0b err=%0b rd=%0d data=0x%08h, expected none",
                 rf_we, err, rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (e[37]) begin
          if (!(err === 1'b1 && rf_we === 1'b0)) begin
            n_fail++;
            $display("FAIL err_event: got we=%0b err=%0b, expected we=0 err=1", rf_we, err);
          end
        end else if (!(rf_we === 1'b1 && err === 1'b0 &&
                       rf_waddr === e[36:32] && rf_wdata === e[31:0])) begin
          n_fail++;
          $display("FAIL write_event: got we=%0b err=%0b rd=%0d data=0x%08h, expected we=1 err=0 rd=%0d data=0x%08h",
                   rf_we, err, rf_waddr, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    instruction = '0;
    wb_sel      = '0;
    alu_result  = '0;
    pc_plus4    = '0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    idle(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rf_we",    {31'd0, rf_we},    32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    check("rst_waddr",    {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata",    rf_wdata,          32'd0);
    check("rst_fwd",      {26'd0, fwd_valid, fwd_rd} | fwd_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy",     {31'd0, busy},     32'd0);
    @(posedge clk); #1;

    // 1: OP x5, ALU result
    push_wr(5'd5, 32'h0000_1234);
    issue(mk(OP_OP, 5'd5, 3'b000), 2'b01, 32'h0000_1234, 32'h0000_0100);
    idle(1);

    // 2: LB x7 off 2, rvalid three cycles later
    push_wr(5'd7, 32'hFFFF_FF80);
    issue(mk(OP_LOAD, 5'd7, 3'b000), 2'b00, 32'h0000_1002, 32'h0);
    @(negedge clk);
    check("lb_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("lb_busy_high",    {31'd0, busy},     32'd1);
    idle(2);
    rvalid_pulse(32'h0080_0000);
    @(negedge clk);
    check("lb_in_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // rvalid in IDLE is ignored (no event expected)
    rvalid_pulse(32'h1111_1111);
    idle(1);

    // 3: JAL x0 -> nothing; then LBU x1 off 3
    issue(mk(OP_JAL, 5'd0, 3'b000), 2'b10, 32'h0, 32'h0000_2004);
    push_wr(5'd1, 32'h0000_00AB);
    issue(mk(OP_LOAD, 5'd1, 3'b100), 2'b00, 32'h0000_2003, 32'h0);
    rvalid_pulse(32'hAB00_0000);
    idle(1);

    // JAL with link, LUI with wb_sel 00, store (no write), wb_sel 11 (err)
    push_wr(5'd31, 32'h0000_3008);
    issue(mk(OP_JAL, 5'd31, 3'b000), 2'b10, 32'hDEAD_0000, 32'h0000_3008);
    push_wr(5'd12, 32'hABCD_E000);
    issue(mk(OP_LUI, 5'd12, 3'b000), 2'b00, 32'hABCD_E000, 32'h0);
    issue(mk(OP_STORE, 5'd13, 3'b010), 2'b01, 32'h5555_5555, 32'h0);
    push_err();
    issue(mk(OP_OP, 5'd6, 3'b000), 2'b11, 32'h7777_7777, 32'h0);
    idle(2);

    // 4: LW x3 timeout after exactly 16 waiting cycles
    push_err();
    issue(mk(OP_LOAD, 5'd3, 3'b010), 2'b00, 32'h0000_4000, 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("timeout_busy_hold", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("timeout_busy_drop", {31'd0, busy},     32'd0);
    check("timeout_in_ready",  {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // rvalid on the last waiting cycle: write wins, no err
    push_wr(5'd9, 32'hCAFE_F00D);
    issue(mk(OP_LOAD, 5'd9, 3'b010), 2'b00, 32'h0000_4004, 32'h0);
    idle(15);
    rvalid_pulse(32'hCAFE_F00D);
    idle(1);

    // Halfword and word formats
    push_wr(5'd10, 32'hFFFF_8001);
    issue(mk(OP_LOAD, 5'd10, 3'b001), 2'b00, 32'h0000_5002, 32'h0);
    rvalid_pulse(32'h8001_0000);
    push_wr(5'd11, 32'h0000_9ABC);
    issue(mk(OP_LOAD, 5'd11, 3'b101), 2'b00, 32'h0000_5000, 32'h0);
    rvalid_pulse(32'h1234_9ABC);
    push_wr(5'd14, 32'hDEAD_BEEF);
    issue(mk(OP_LOAD, 5'd14, 3'b010), 2'b00, 32'h0000_5008, 32'h0);
    rvalid_pulse(32'hDEAD_BEEF);
    // Load to x0: waits for data but writes nothing
    issue(mk(OP_LOAD, 5'd0, 3'b010), 2'b00, 32'h0000_500C, 32'h0);
    @(negedge clk);
    check("x0_load_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rvalid_pulse(32'h0BAD_0BAD);
    idle(1);

    // 5: LH x4 off 1 -> err, never busy; illegal funct3 -> err
    push_err();
    issue(mk(OP_LOAD, 5'd4, 3'b001), 2'b00, 32'h0000_6001, 32'h0);
    @(negedge clk);
    check("misalign_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    push_err();
    issue(mk(OP_LOAD, 5'd4, 3'b011), 2'b00, 32'h0000_6000, 32'h0);
    idle(1);

    // rst during WAIT_LOAD, later rvalid ignored
    issue(mk(OP_LOAD, 5'd2, 3'b000), 2'b00, 32'h0000_7000, 32'h0);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_wait_busy",     {31'd0, busy},     32'd0);
    @(posedge clk); #1;
    rvalid_pulse(32'h0000_00FF);
    idle(2);

    // 6: four back-to-back OP-IMM accepts
    for (int i = 1; i <= 4; i++) begin
      push_wr(5'(i + 20), 32'h0000_0011 * i);
      issue(mk(OP_OPIMM, 5'(i + 20), 3'b000), 2'b01, 32'h0000_0011 * i, 32'h0);
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    end
    idle(4);

    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
